// File: rtl/mix_pkg.sv
// Shared types and constants for the MIX block-transfer controller.
// A MIX word is a sign bit (bit 30) above five 6-bit bytes.
package mix_pkg;

  localparam int WORD_W     = 31;
  localparam int ADDR_W     = 12;
  localparam int MEM_WORDS  = 4000;
  localparam int LEN_W      = 7;
  localparam int STARVE_LIM = 4;

  typedef logic [WORD_W-1:0] mixWord_t;
  typedef logic [ADDR_W-1:0] mixAddr_t;
  typedef logic [LEN_W-1:0]  mixLen_t;

  typedef enum logic [2:0] {
    IDLE,
    IN_WAIT,
    IN_WR,
    OUT_RD,
    OUT_LAT,
    OUT_SEND,
    FIN
  } dmaState_e;

  // One bit wider than an address so base+len near the top of memory cannot wrap.
  function automatic logic blockFits(mixAddr_t base, mixLen_t len);
    logic [ADDR_W:0] endAddr;
    endAddr = {1'b0, base} + {{(ADDR_W + 1 - LEN_W){1'b0}}, len};
    return endAddr <= (ADDR_W + 1)'(MEM_WORDS);
  endfunction

endpackage

// File: rtl/mix_io_dma_if.sv
// Signal bundle between the block-transfer controller and its surroundings:
// core control, CPU memory requests, the BRAM port and the device streams.
interface mix_io_dma_if;
  import mix_pkg::*;

  logic     start;
  logic     dir;
  mixAddr_t base;
  mixLen_t  len;
  logic     busy;
  logic     done;
  logic     err;

  logic     cpu_req;
  logic     cpu_we;
  mixAddr_t cpu_addr;
  mixWord_t cpu_wdata;
  logic     cpu_gnt;

  mixAddr_t mem_addr;
  logic     mem_we;
  mixWord_t mem_wdata;
  mixWord_t mem_rdata;

  logic     din_valid;
  mixWord_t din_data;
  logic     din_ready;

  logic     dout_valid;
  mixWord_t dout_data;
  logic     dout_ready;

  modport master (
    input  start, dir, base, len,
    output busy, done, err,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    input  din_valid, din_data,
    output din_ready,
    output dout_valid, dout_data,
    input  dout_ready
  );

  modport slave (
    output start, dir, base, len,
    input  busy, done, err,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    output din_valid, din_data,
    input  din_ready,
    input  dout_valid, dout_data,
    output dout_ready
  );

endinterface

// File: rtl/mix_mem_arb.sv
// Single memory port shared by the CPU and the transfer engine: the CPU wins
// by default, but the engine is forced a slot after STARVE_LIM denied cycles.
module mix_mem_arb
  import mix_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     cpuReq,
  input  logic     cpuWe,
  input  mixAddr_t cpuAddr,
  input  mixWord_t cpuWdata,
  output logic     cpuGnt,
  input  logic     dmaNeed,
  input  logic     dmaWe,
  input  mixAddr_t dmaAddr,
  input  mixWord_t dmaWdata,
  output logic     dmaGnt,
  output mixAddr_t memAddr,
  output logic     memWe,
  output mixWord_t memWdata
);

  localparam int STARVE_W = $clog2(STARVE_LIM + 1);

  logic [STARVE_W-1:0] starveCnt;
  logic                forceDma;

  assign forceDma = dmaNeed && (starveCnt == STARVE_W'(STARVE_LIM));
  assign cpuGnt   = cpuReq && !forceDma;
  assign dmaGnt   = dmaNeed && !cpuGnt;

  // NOTE: state is updated with <= so every register samples pre-edge values;
  // blocking assignments here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      starveCnt <= '0;
    end else if (dmaGnt) begin
      starveCnt <= '0;
    end else if (dmaNeed && !forceDma) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  // NOTE: every output gets a default before the branches, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    memAddr  = dmaAddr;
    memWdata = dmaWdata;
    memWe    = 1'b0;
    if (cpuGnt) begin
      memAddr  = cpuAddr;
      memWdata = cpuWdata;
      memWe    = cpuWe;
    end else if (dmaGnt) begin
      memWe = dmaWe;
    end
  end

endmodule

// File: rtl/mix_io_dma.sv
// Block-transfer controller for MIX IN/OUT: moves len words between memory
// starting at base and the device stream, one word at a time.
module mix_io_dma
  import mix_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mix_io_dma_if.master bus
);

  dmaState_e state;
  dmaState_e stateNext;
  mixAddr_t  baseR;
  mixLen_t   lenR;
  mixLen_t   idx;
  mixWord_t  hold;
  mixWord_t  doutData;
  logic      errR;
  logic      zeroDone;

  logic      dmaNeed;
  logic      dmaWe;
  logic      dmaGnt;
  mixAddr_t  dmaAddr;
  logic      idxLast;
  logic      startOk;

  assign dmaNeed = (state == IN_WR) || (state == OUT_RD);
  assign dmaWe   = (state == IN_WR);
  assign dmaAddr = baseR + ADDR_W'(idx);
  assign idxLast = (idx + 1'b1) == lenR;
  assign startOk = bus.start && blockFits(bus.base, bus.len) && (bus.len != '0);

  mix_mem_arb uArb (
    .clk      (clk),
    .reset    (reset),
    .cpuReq   (bus.cpu_req),
    .cpuWe    (bus.cpu_we),
    .cpuAddr  (bus.cpu_addr),
    .cpuWdata (bus.cpu_wdata),
    .cpuGnt   (bus.cpu_gnt),
    .dmaNeed  (dmaNeed),
    .dmaWe    (dmaWe),
    .dmaAddr  (dmaAddr),
    .dmaWdata (hold),
    .dmaGnt   (dmaGnt),
    .memAddr  (bus.mem_addr),
    .memWe    (bus.mem_we),
    .memWdata (bus.mem_wdata)
  );

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (startOk) stateNext = bus.dir ? OUT_RD : IN_WAIT;
      IN_WAIT:  if (bus.din_valid) stateNext = IN_WR;
      IN_WR:    if (dmaGnt) stateNext = idxLast ? FIN : IN_WAIT;
      OUT_RD:   if (dmaGnt) stateNext = OUT_LAT;
      OUT_LAT:  stateNext = OUT_SEND;
      OUT_SEND: if (bus.dout_ready) stateNext = idxLast ? FIN : OUT_RD;
      FIN:      stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baseR    <= '0;
      lenR     <= '0;
      idx      <= '0;
      doutData <= '0;
      errR     <= 1'b0;
      zeroDone <= 1'b0;
    end else begin
      state    <= stateNext;
      errR     <= 1'b0;
      zeroDone <= 1'b0;
      // A rejected or empty request still latches its arguments but never leaves IDLE.
      if (state == IDLE && bus.start) begin
        baseR    <= bus.base;
        lenR     <= bus.len;
        idx      <= '0;
        errR     <= !blockFits(bus.base, bus.len);
        zeroDone <= blockFits(bus.base, bus.len) && (bus.len == '0);
      end
      if ((state == IN_WR && dmaGnt) || (state == OUT_SEND && bus.dout_ready)) begin
        idx <= idx + 1'b1;
      end
      if (state == OUT_LAT) begin
        doutData <= bus.mem_rdata;
      end
    end
  end

  // NOTE: the holding register is pure datapath, only read after a handshake
  // has loaded it, so it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == IN_WAIT && bus.din_valid) begin
      hold <= bus.din_data;
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == FIN) || zeroDone;
  assign bus.err        = errR;
  assign bus.din_ready  = (state == IN_WAIT);
  assign bus.dout_valid = (state == OUT_SEND);
  assign bus.dout_data  = doutData;

endmodule

// File: tb/tb_mix_io_dma.sv
// Scoreboard bench for mix_io_dma: expected memory writes and device words are
// queued as stimulus is issued and retired as the DUT produces them.
module tb_mix_io_dma;
  import mix_pkg::*;

  typedef struct {
    mixAddr_t addr;
    mixWord_t data;
  } wrExp_t;

  logic clk;
  logic reset;
  logic memInit;

  mix_io_dma_if bus ();

  mix_io_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic mixWord_t memPat(input int i);
    logic [31:0] v;
    v = (32'(i) * 32'h9E37_79B1) ^ 32'h5555_0000;
    return v[30:0];
  endfunction

  // ---------------- memory model ----------------
  mixWord_t memArr [0:4095];
  mixWord_t shadow [0:4095];

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 4096; i++) memArr[i] <= memPat(i);
    end else if (bus.mem_we) begin
      memArr[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= memArr[bus.mem_addr];
  end

  // ---------------- scoreboards and monitors ----------------
  wrExp_t   expQ [$];
  mixWord_t doutQ [$];
  mixWord_t dinQ [$];

  int       doneCnt = 0;
  int       errCnt  = 0;
  int       dinHs   = 0;
  int       doutHs  = 0;
  int       slotCnt = 0;
  int       sinceHs = 0;
  logic     gapEn   = 1'b0;
  logic     gapArmed = 1'b0;
  logic     cpuChk  = 1'b0;
  logic     cpuArm  = 1'b0;
  mixAddr_t cpuAddrS;
  logic     holdArm = 1'b0;
  mixWord_t heldData;
  logic     randReady = 1'b0;
  wrExp_t   wrE;
  mixWord_t doutE;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) doneCnt++;
      if (bus.err) errCnt++;
      if (bus.din_valid && bus.din_ready) dinHs++;

      if (bus.mem_we) begin
        check("wr_expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          wrE = expQ.pop_front();
          check("wr_addr", 64'(bus.mem_addr), 64'(wrE.addr));
          check("wr_data", 64'(bus.mem_wdata), 64'(wrE.data));
        end
      end

      if (holdArm && bus.dout_valid) check("dout_stable", 64'(bus.dout_data), 64'(heldData));
      holdArm  = bus.dout_valid && !bus.dout_ready;
      heldData = bus.dout_data;

      if (bus.dout_valid && bus.dout_ready) begin
        doutHs++;
        check("dout_expected", 64'(doutQ.size() != 0), 64'd1);
        if (doutQ.size() != 0) begin
          doutE = doutQ.pop_front();
          check("dout_data", 64'(bus.dout_data), 64'(doutE));
        end
        sinceHs  = 0;
        gapArmed = gapEn;
      end else begin
        sinceHs++;
      end

      if (gapEn && bus.cpu_req && !bus.cpu_gnt) begin
        slotCnt++;
        if (gapArmed) check("slot_gap", 64'(sinceHs), 64'(STARVE_LIM + 1));
      end

      if (cpuArm) check("cpu_rdata", 64'(bus.mem_rdata), 64'(shadow[cpuAddrS]));
      cpuArm   = cpuChk && bus.cpu_gnt && !bus.cpu_we;
      cpuAddrS = bus.cpu_addr;
    end
  end

  // ---------------- device drivers ----------------
  logic dinHsNow;

  initial begin
    bus.din_valid = 1'b0;
    bus.din_data  = '0;
    forever begin
      @(negedge clk);
      dinHsNow = bus.din_valid && bus.din_ready;
      @(posedge clk);
      #1;
      if (dinHsNow && dinQ.size() > 0) void'(dinQ.pop_front());
      bus.din_valid = (dinQ.size() > 0);
      bus.din_data  = (dinQ.size() > 0) ? dinQ[0] : '0;
    end
  end

  initial begin
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.dout_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- helper tasks ----------------
  task automatic startXfer(input logic d, input int b, input int l);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.dir   = d;
    bus.base  = ADDR_W'(b);
    bus.len   = LEN_W'(l);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int   n;
    int   idleCyc;
    logic seen;
    n       = 0;
    idleCyc = 0;
    seen    = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        seen = 1'b1;
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd1);
      end else if (!bus.busy) begin
        idleCyc++;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_held"}, 64'(idleCyc), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  int       d0;
  int       e0;
  int       h0;
  int       o0;
  int       seenW;
  int       n;
  mixWord_t negA;
  mixWord_t negB;

  initial begin
    reset         = 1'b1;
    memInit       = 1'b1;
    bus.start     = 1'b0;
    bus.dir       = 1'b0;
    bus.base      = '0;
    bus.len       = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 4096; i++) shadow[i] = memPat(i);

    repeat (2) @(posedge clk);
    #1 memInit = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_din_ready", 64'(bus.din_ready), 64'd0);
    check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_dout_data", 64'(bus.dout_data), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // IN of three words, no CPU traffic
    d0 = doneCnt; e0 = errCnt; h0 = dinHs;
    for (int i = 0; i < 3; i++) begin
      dinQ.push_back(WORD_W'(i + 1));
      expQ.push_back('{addr: ADDR_W'(100 + i), data: WORD_W'(i + 1)});
    end
    startXfer(1'b0, 100, 3);
    waitDone("in3", 60);
    idle(2);
    check("in3_handshakes", 64'(dinHs - h0), 64'd3);
    check("in3_done_count", 64'(doneCnt - d0), 64'd1);
    check("in3_err_count", 64'(errCnt - e0), 64'd0);
    check("in3_writes_left", 64'(expQ.size()), 64'd0);

    // OUT at the top of memory with the CPU requesting every cycle
    d0 = doneCnt;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = ADDR_W'(7);
    cpuChk    = 1'b1;
    randReady = 1'b1;
    gapEn     = 1'b1;
    gapArmed  = 1'b0;
    slotCnt   = 0;
    for (int i = 0; i < 10; i++) doutQ.push_back(shadow[3990 + i]);
    startXfer(1'b1, 3990, 10);
    waitDone("out10", 800);
    idle(2);
    bus.cpu_req = 1'b0;
    cpuChk    = 1'b0;
    randReady = 1'b0;
    gapEn     = 1'b0;
    idle(2);
    check("out10_dma_slots", 64'(slotCnt), 64'd10);
    check("out10_words_left", 64'(doutQ.size()), 64'd0);
    check("out10_done_count", 64'(doneCnt - d0), 64'd1);

    // range violation, then the largest block that still fits
    d0 = doneCnt; e0 = errCnt;
    startXfer(1'b0, 3995, 6);
    @(negedge clk);
    check("range_err_pulse", 64'(bus.err), 64'd1);
    check("range_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("range_busy_after", 64'(bus.busy), 64'd0);
      check("range_err_after", 64'(bus.err), 64'd0);
    end
    check("range_err_count", 64'(errCnt - e0), 64'd1);
    check("range_done_count", 64'(doneCnt - d0), 64'd0);
    for (int i = 0; i < 6; i++) doutQ.push_back(shadow[3994 + i]);
    startXfer(1'b1, 3994, 6);
    waitDone("fit6", 100);
    idle(2);
    check("fit6_err_count", 64'(errCnt - e0), 64'd1);
    check("fit6_words_left", 64'(doutQ.size()), 64'd0);

    // zero-length transfer
    d0 = doneCnt; e0 = errCnt; o0 = doutHs;
    startXfer(1'b0, 50, 0);
    @(negedge clk);
    check("len0_done", 64'(bus.done), 64'd1);
    check("len0_err", 64'(bus.err), 64'd0);
    check("len0_busy", 64'(bus.busy), 64'd0);
    idle(3);
    check("len0_done_count", 64'(doneCnt - d0), 64'd1);
    check("len0_err_count", 64'(errCnt - e0), 64'd0);

    // negative words round-trip; a start during the IN is ignored
    negA = {1'b1, 30'o0000000001};
    negB = {1'b1, 30'o7777777777};
    d0 = doneCnt; o0 = doutHs;
    dinQ.push_back(negA);
    dinQ.push_back(negB);
    expQ.push_back('{addr: ADDR_W'(200), data: negA});
    expQ.push_back('{addr: ADDR_W'(201), data: negB});
    startXfer(1'b0, 200, 2);
    startXfer(1'b1, 0, 5);
    waitDone("neg_in", 60);
    idle(3);
    check("neg_in_done_count", 64'(doneCnt - d0), 64'd1);
    check("neg_in_writes_left", 64'(expQ.size()), 64'd0);
    check("neg_in_no_dout", 64'(doutHs - o0), 64'd0);
    doutQ.push_back(negA);
    doutQ.push_back(negB);
    startXfer(1'b1, 200, 2);
    waitDone("neg_out", 60);
    idle(2);
    check("neg_out_words_left", 64'(doutQ.size()), 64'd0);

    // reset after two of five words
    for (int i = 0; i < 5; i++) begin
      dinQ.push_back(WORD_W'(9 * (i + 1)));
      expQ.push_back('{addr: ADDR_W'(300 + i), data: WORD_W'(9 * (i + 1))});
    end
    startXfer(1'b0, 300, 5);
    seenW = 0;
    n     = 0;
    while (seenW < 2 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.mem_we) seenW++;
    end
    check("abort_two_writes", 64'(seenW), 64'd2);
    @(posedge clk);
    #1 reset = 1'b1;
    dinQ.delete();
    expQ.delete();
    d0 = doneCnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_din_ready", 64'(bus.din_ready), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(4);
    check("abort_done_count", 64'(doneCnt - d0), 64'd0);
    dinQ.push_back(WORD_W'(511));
    expQ.push_back('{addr: ADDR_W'(300), data: WORD_W'(511)});
    startXfer(1'b0, 300, 1);
    waitDone("after_abort", 40);
    idle(2);
    check("after_abort_done_count", 64'(doneCnt - d0), 64'd1);
    check("after_abort_writes_left", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
